// File: rtl/alu_iterative_muldiv.sv
// Execute-stage integer ALU with RISC-V M-extension multiply/divide.
//
// Purpose:
//   Single-cycle RV32I ALU operations (registered, 1-cycle latency) plus
//   iterative shift-add multiply and restoring divide (XLEN+1 cycle latency).
//   The result is held in DONE until the consumer accepts it. A new request
//   can be accepted on the same edge that the held result is consumed.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            synchronous abort of any in-flight or held operation
//   in_valid/ready   request handshake (op, a, b captured on accept)
//   op               5-bit operation code
//   a, b             operands (rs1, rs2/immediate)
//   out_valid/ready  result handshake
//   result, zero     registered result and its zero flag
module alu_iterative_muldiv #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_XOR = 5'd2,  OP_OR = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9, OP_LUI = 5'd10;
  localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
  localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22,    OP_REMU = 5'd23;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state_q, state_n;
  logic [4:0]          op_q;
  logic                neg_q;     // sign to apply to the final magnitude
  logic [XLEN-1:0]     m_q;       // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0]   p_q;       // mul: {partial sum, multiplier}; div: {remainder, quotient}
  logic [SHW-1:0]      cnt_q;
  logic [XLEN-1:0]     result_q;

  logic                accept, iterate, last_iter;
  logic                is_mul, is_div, a_sgn, b_sgn, neg, div_zero, div_ovf;
  logic [XLEN-1:0]     a_mag, b_mag, imm_res, fin_res;
  logic [SHW-1:0]      shamt;
  logic [2*XLEN-1:0]   p_step, prod;
  logic [XLEN:0]       sum, trial;

  // Request decode: operand magnitudes, final sign, special cases, ALU result.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    is_mul   = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    is_div   = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    a_sgn    = 1'b0;
    b_sgn    = 1'b0;
    shamt    = b[SHW-1:0];
    imm_res  = '0;
    case (op)
      OP_MULH:        begin a_sgn = a[XLEN-1]; b_sgn = b[XLEN-1]; end
      OP_MULHSU:      a_sgn = a[XLEN-1];
      OP_DIV, OP_REM: begin a_sgn = a[XLEN-1]; b_sgn = b[XLEN-1]; end
      default: ;
    endcase
    a_mag    = a_sgn ? -a : a;
    b_mag    = b_sgn ? -b : b;
    // Remainder follows the dividend; products and quotients follow a ^ b.
    neg      = (op == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
    div_zero = is_div && (b == '0);
    div_ovf  = (op == OP_DIV || op == OP_REM) && (a == MOST_NEG) && (b == '1);
    iterate  = is_mul || (is_div && !div_zero && !div_ovf);

    case (op)
      OP_ADD:  imm_res = a + b;
      OP_SUB:  imm_res = a - b;
      OP_XOR:  imm_res = a ^ b;
      OP_OR:   imm_res = a | b;
      OP_AND:  imm_res = a & b;
      OP_SLL:  imm_res = a << shamt;
      OP_SRL:  imm_res = a >> shamt;
      OP_SRA:  imm_res = $unsigned($signed(a) >>> shamt);
      OP_SLT:  imm_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: imm_res = {{(XLEN-1){1'b0}}, a < b};
      OP_LUI:  imm_res = b;
      default: imm_res = '0;
    endcase
    if (div_zero)
      imm_res = (op == OP_DIV || op == OP_DIVU) ? '1 : a;
    else if (div_ovf)
      imm_res = (op == OP_DIV) ? a : '0;
  end

  // One iteration step: shift-add for MUL, restoring subtract for DIV.
  always_comb begin
    sum   = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
    trial = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]} - {1'b0, m_q};
    if (state_q == MUL)
      p_step = {sum, p_q[XLEN-1:1]};
    else if (!trial[XLEN])
      p_step = {trial[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
    else
      p_step = {p_q[2*XLEN-2:0], 1'b0};

    // Sign is applied to the magnitude produced by the last step.
    prod = neg_q ? -p_step : p_step;
    case (op_q)
      OP_MUL:                     fin_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            fin_res = neg_q ? -p_step[XLEN-1:0] : p_step[XLEN-1:0];
      default:                    fin_res = neg_q ? -p_step[2*XLEN-1:XLEN] : p_step[2*XLEN-1:XLEN];
    endcase
  end

  assign last_iter = &cnt_q;

  // Next state. flush overrides everything, including an accept on the same edge.
  always_comb begin
    state_n = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE:     accept = in_valid;
      MUL, DIV: if (last_iter) state_n = DONE;
      DONE:     if (out_ready) begin
                  accept  = in_valid;
                  state_n = IDLE;
                end
      default:  state_n = IDLE;
    endcase
    if (accept)
      state_n = !iterate ? DONE : (is_mul ? MUL : DIV);
    if (flush) begin
      state_n = IDLE;
      accept  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset as well; they are few and it keeps
    // the reset value of result well defined.
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      m_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_n;
      if (accept) begin
        op_q  <= op;
        neg_q <= neg;
        m_q   <= is_mul ? a_mag : b_mag;
        p_q   <= {{XLEN{1'b0}}, (is_mul ? b_mag : a_mag)};
        cnt_q <= '0;
        if (!iterate)
          result_q <= imm_res;
      end else if ((state_q == MUL || state_q == DIV) && !flush) begin
        p_q   <= p_step;
        cnt_q <= cnt_q + 1'b1;
        if (last_iter)
          result_q <= fin_res;
      end
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_iterative_muldiv.sv
// Self-checking bench for alu_iterative_muldiv: directed corners, backpressure,
// flush/reset aborts, randomized traffic against an arithmetic reference model,
// and a small XLEN=16 instance.
module tb_alu_iterative_muldiv;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd5, SRA = 5'd7, SLTU = 5'd9;
  localparam logic [4:0] MUL = 5'd16, MULH = 5'd17, MULHU = 5'd19;
  localparam logic [4:0] DIV = 5'd20, DIVU = 5'd21, REM = 5'd22, REMU = 5'd23;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero;
  logic [4:0]  op;
  logic [31:0] a, b, result;
  logic        rand_rdy, rnd_rdy, fixed_rdy;

  logic        iv16, ir16, ov16, z16;
  logic [4:0]  op16;
  logic [15:0] a16, b16, res16;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  assign out_ready = rand_rdy ? rnd_rdy : fixed_rdy;

  alu_iterative_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  alu_iterative_muldiv #(.XLEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(iv16), .in_ready(ir16),
    .op(op16), .a(a16), .b(b16), .out_valid(ov16), .out_ready(1'b1),
    .result(res16), .zero(z16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: RISC-V semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    p  = '0;
    case (o)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x ^ y;
      5'd3:  return x | y;
      5'd4:  return x & y;
      5'd5:  return x << y[4:0];
      5'd6:  return x >> y[4:0];
      5'd7:  return 32'(sx >>> y[4:0]);
      5'd8:  return (sx < sy) ? 32'd1 : 32'd0;
      5'd9:  return (x < y) ? 32'd1 : 32'd0;
      5'd10: return y;
      5'd16: begin p = sx * sy; return p[31:0];  end
      5'd17: begin p = sx * sy; return p[63:32]; end
      5'd18: begin p = sx * uy; return p[63:32]; end
      5'd19: begin p = ux * uy; return p[63:32]; end
      5'd20: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return 32'(sx / sy);
      end
      5'd21: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd22: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sx % sy);
      end
      5'd23: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  // Accept-to-out_valid latency: iterative ops take XLEN+1, everything else 1.
  function automatic int exp_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o >= 5'd16 && o <= 5'd19) return 33;
    if (o >= 5'd20 && o <= 5'd23) begin
      if (y == 0) return 1;
      if ((o == 5'd20 || o == 5'd22) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return 1;
  endfunction

  // Drive a request, wait (bounded) for acceptance, record the expectation.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp);
    int waited = 0;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!in_ready) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    sb.push_back('{res: exp, acc: cyc, lat: exp_lat(o, x, y)});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 15);
      default: return $urandom();
    endcase
  endfunction

  task automatic run16(input logic [4:0] o, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] r, output int lat);
    int n;
    @(negedge clk);
    op16 = o; a16 = x; b16 = y; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    n = 1;
    while (!ov16 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    r   = res16;
    lat = n;
  endtask

  // Monitor: checks latency when a result first appears, value and zero on consume.
  initial begin
    exp_t e;
    bit   seen = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          if (!seen) begin
            check("latency", cyc - sb[0].acc, sb[0].lat);
            seen = 1'b1;
          end
          if (out_ready) begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("zero", {31'b0, zero}, {31'b0, e.res == 32'd0});
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_r;
    logic        held_z, stable, saw;
    logic [4:0]  ro;
    logic [31:0] ra, rb;
    logic [15:0] r16;
    int          lat16, n;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    rand_rdy = 1'b0; rnd_rdy = 1'b0; fixed_rdy = 1'b1;
    iv16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd1);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // ALU sweep, multiply and divide corners
    issue(ADD,   32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    issue(SUB,   32'd5,         32'd5,         32'h0000_0000);
    issue(SRA,   32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    issue(SLTU,  32'd1,         32'hFFFF_FFFF, 32'h0000_0001);
    issue(MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(MUL,   32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    issue(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    issue(REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    issue(DIVU,  32'h1234_5678, 32'd0,         32'hFFFF_FFFF);
    issue(REMU,  32'd9,         32'd0,         32'h0000_0009);
    issue(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue(REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    drain();

    // Backpressure: result held while out_ready is low, then same-edge handoff
    fixed_rdy = 1'b0;
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    held_r = result;
    held_z = zero;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk); #1;
      if (!out_valid || in_ready || result !== held_r || zero !== held_z) stable = 1'b0;
    end
    check("bp_stable", {31'b0, stable}, 32'd1);
    check("bp_held_result", held_r, 32'hFFFF_FFFD);
    @(negedge clk);
    fixed_rdy = 1'b1;
    op = ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    #1;
    check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    sb.push_back('{res: 32'd7, acc: cyc, lat: 1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Abort by flush at iteration 12 of mulhu
    issue(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
    repeat (12) @(negedge clk);
    flush = 1'b1;
    sb.delete();
    @(negedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check("flush_no_out_valid", {31'b0, saw}, 32'd0);

    // Abort by asynchronous reset mid-iteration; result is non-zero beforehand
    issue(ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
    drain();
    issue(MULHU, 32'hFFFF_FFFF, 32'h0000_1234, 32'h0);
    repeat (12) @(negedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_result", result, 32'd0);
    check("arst_zero", {31'b0, zero}, 32'd1);
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    repeat (400) begin
      ro = 5'($urandom_range(0, 31));
      ra = rnd_opnd();
      rb = rnd_opnd();
      issue(ro, ra, rb, model(ro, ra, rb));
    end
    drain();
    rand_rdy = 1'b0;

    // XLEN=16 build
    run16(MUL, 16'h00FF, 16'h0101, r16, lat16);
    check("x16_mul_result", {16'b0, r16}, 32'h0000_FFFF);
    check("x16_mul_latency", lat16, 32'd17);
    run16(SLL, 16'h0001, 16'h0013, r16, lat16);
    check("x16_sll_result", {16'b0, r16}, 32'h0000_0008);
    check("x16_sll_latency", lat16, 32'd1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
